lru_replace_ctrl: RTL and testbench
===================================

Name: lru_replace_ctrl

Overview:
- Request-side controller for the 4-way cache's matrix LRU tracker.
- Consumes the tracker's per-way row-OR status vector, where a 0 bit marks the least-recently-used way.
- On a hit, it forwards the hit way. On a miss, it selects a victim, runs the line-fill handshake with memory, then drives the one-hot way-access pulse that updates the tracker.

Parameters:
- LINE_BEATS, 4, number of mem_ack beats per line fill (2..16).
- ACK_TIMEOUT, 64, max consecutive cycles without mem_ack during a fill before abort (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  access request, sampled only in IDLE.
- req_hit  input  1  request hit in tag compare.
- req_hit_way  input  4  one-hot hit way.
- way_invalid  input  4  per-way invalid flags for the indexed set.
- lru_status  input  4  tracker row-OR vector; bit i = 0 means way i is an LRU candidate.
- mem_ack  input  1  one fill beat accepted/returned this cycle.
- mem_req  output  1  fill request, held for the whole fill.
- fill_beat  output  4  current beat index (zero-extended).
- victim_way  output  2  registered victim index, valid from FILL until the next miss.
- way_access  output  4  one-hot update pulse to the LRU tracker.
- busy  output  1  high in every state except IDLE.
- fill_done  output  1  one-cycle pulse when a fill completes.
- fill_err  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; beat counter, timeout counter and round-robin pointer cleared.
- States: IDLE, SELECT, FILL, UPDATE.
- IDLE, hit path:
  - Condition: req_valid & req_hit & req_hit_way≠0.
  - Latch the lowest set bit of req_hit_way, then go to UPDATE.
  - Latency: request at cycle N, way_access at cycle N+1.
- IDLE, miss path:
  - Condition: req_valid & (!req_hit | req_hit_way==0).
  - Go to SELECT.
- IDLE: mem_ack is ignored.
- SELECT (one cycle): register victim_way using this priority:
  1. lowest-index set bit of way_invalid;
  2. else lowest-index 0 bit of lru_status;
  3. else (lru_status==4'b1111) the round-robin pointer, then increment the pointer mod 4.
  - Go to FILL.
- FILL:
  - mem_req=1 from the first FILL cycle (request cycle N+2).
  - Each cycle with mem_ack=1 increments fill_beat and clears the timeout counter.
  - Each cycle with mem_ack=0 increments the timeout counter.
  - On the ack of beat LINE_BEATS-1: drop mem_req the next cycle and go to UPDATE.
  - If the timeout counter reaches ACK_TIMEOUT: pulse fill_err, drop mem_req, return to IDLE. No way_access is issued and victim_way is held.
- UPDATE (one cycle):
  - way_access = one-hot of the latched way.
  - fill_done=1 only if entered from FILL.
  - Return to IDLE. A new req_valid is accepted the following cycle.
- Boundary rules:
  - req_valid while busy is ignored; the requester must hold it.
  - A multi-hot req_hit_way uses its lowest bit.
  - mem_ack on the same cycle as a timeout-counter terminal value counts as a beat; no abort.
  - Reset mid-FILL drops mem_req immediately; fill_beat returns to 0.
- Width rules:
  - Beat counter is 4 bits and wraps only through reset/next fill.
  - Timeout counter width is $clog2(ACK_TIMEOUT+1).
  - way_access is never multi-hot; it is nonzero only in UPDATE.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, SELECT=1, FILL=2, UPDATE=3);
  - NUM_WAYS=4;
  - a one-hot/index conversion function used by both this block and the tracker.
- One natural sub-module: lru_victim_pick. It is the combinational priority selector (invalid → LRU zero → round-robin) with the round-robin pointer register.

Test Plan:
- Hit, way 2:
  - Stimulus: reset, then req_valid=1, req_hit=1, req_hit_way=4'b0100.
  - Required: way_access=4'b0100 for exactly one cycle at N+1; mem_req never asserts.
- Miss with an invalid way:
  - Stimulus: way_invalid=4'b1010, lru_status=4'b1110.
  - Required: victim_way=1; 4 acks → fill_done pulse, then way_access=4'b0010.
- Miss, all ways valid:
  - Stimulus: lru_status=4'b1011.
  - Required: victim_way=2; with mem_ack every other cycle, mem_req stays high for 8 cycles; fill_beat steps 0..3; way_access=4'b0100.
- All-ones status, three misses:
  - Stimulus: lru_status=4'b1111 for three consecutive misses.
  - Required: victims 0, 1, 2 (round-robin).
- Timeout:
  - Stimulus: ACK_TIMEOUT=8; miss, then no mem_ack.
  - Required: fill_err pulses after 8 FILL cycles; mem_req drops; way_access stays 0; busy returns to 0.
- Reset mid-fill:
  - Stimulus: assert reset after 2 beats.
  - Required: mem_req, busy and fill_beat go to 0 asynchronously; the next miss restarts at beat 0.

Source files
------------

// File: rtl/lru_replace_ctrl_pkg.sv
// Shared definitions for the 4-way LRU replacement controller and its tracker:
// state encoding, way count and one-hot/index helpers.
package lru_replace_ctrl_pkg;

    localparam int NUM_WAYS  = 4;
    localparam int WAY_IDX_W = $clog2(NUM_WAYS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_FILL   = 2'd2,
        ST_UPDATE = 2'd3
    } lru_state_e;

    // Lowest set bit wins, so a multi-hot vector still yields one index.
    function automatic logic [WAY_IDX_W-1:0] oh2idx(input logic [NUM_WAYS-1:0] oh);
        logic [WAY_IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (oh[i]) idx = WAY_IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [NUM_WAYS-1:0] idx2oh(input logic [WAY_IDX_W-1:0] idx);
        return NUM_WAYS'(1) << idx;
    endfunction

endpackage

// File: rtl/lru_replace_ctrl_if.sv
// Request, tracker-status and line-fill signals of the LRU replacement controller.
// The controller uses the slave side; the requester/memory side uses master.
interface lru_replace_ctrl_if;
    import lru_replace_ctrl_pkg::*;

    logic                 req_valid;
    logic                 req_hit;
    logic [NUM_WAYS-1:0]  req_hit_way;
    logic [NUM_WAYS-1:0]  way_invalid;
    logic [NUM_WAYS-1:0]  lru_status;
    logic                 mem_ack;
    logic                 mem_req;
    logic [3:0]           fill_beat;
    logic [WAY_IDX_W-1:0] victim_way;
    logic [NUM_WAYS-1:0]  way_access;
    logic                 busy;
    logic                 fill_done;
    logic                 fill_err;

    modport master (
        output req_valid, req_hit, req_hit_way, way_invalid, lru_status, mem_ack,
        input  mem_req, fill_beat, victim_way, way_access, busy, fill_done, fill_err
    );

    modport slave (
        input  req_valid, req_hit, req_hit_way, way_invalid, lru_status, mem_ack,
        output mem_req, fill_beat, victim_way, way_access, busy, fill_done, fill_err
    );

endinterface

// File: rtl/lru_victim_pick.sv
// Victim priority selector: first invalid way, else first LRU candidate (status 0),
// else round-robin. The pointer only advances when the round-robin choice is consumed.
module lru_victim_pick
    import lru_replace_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 adv_i,
    input  logic [NUM_WAYS-1:0]  way_invalid_i,
    input  logic [NUM_WAYS-1:0]  lru_status_i,
    output logic [WAY_IDX_W-1:0] victim_o
);

    logic [WAY_IDX_W-1:0] rr_q;
    logic [WAY_IDX_W-1:0] rr_d;
    logic                 use_rr;

    always_comb begin
        use_rr   = 1'b0;
        victim_o = rr_q;
        if (|way_invalid_i) begin
            victim_o = oh2idx(way_invalid_i);
        end else if (!(&lru_status_i)) begin
            victim_o = oh2idx(~lru_status_i);
        end else begin
            use_rr = 1'b1;
        end
        rr_d = (adv_i && use_rr) ? rr_q + WAY_IDX_W'(1) : rr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/lru_replace_ctrl.sv
// Request-side controller for the matrix LRU tracker: forwards hits, picks a victim on
// a miss, runs the line fill with an ack timeout, then pulses the tracker update.
module lru_replace_ctrl
    import lru_replace_ctrl_pkg::*;
#(
    parameter int LINE_BEATS  = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    lru_replace_ctrl_if.slave bus
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    lru_state_e           state_q;
    logic [3:0]           beat_q;
    logic [TW-1:0]        tmo_q;
    logic [WAY_IDX_W-1:0] victim_q;
    logic [NUM_WAYS-1:0]  way_access_q;
    logic                 mem_req_q;
    logic                 busy_q;
    logic                 fill_done_q;
    logic                 fill_err_q;
    logic [WAY_IDX_W-1:0] pick_way;

    lru_victim_pick u_pick (
        .clk          (clk),
        .reset        (reset),
        .adv_i        (state_q == ST_SELECT),
        .way_invalid_i(bus.way_invalid),
        .lru_status_i (bus.lru_status),
        .victim_o     (pick_way)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            tmo_q        <= '0;
            victim_q     <= '0;
            way_access_q <= '0;
            mem_req_q    <= 1'b0;
            busy_q       <= 1'b0;
            fill_done_q  <= 1'b0;
            fill_err_q   <= 1'b0;
        end else begin
            way_access_q <= '0;
            fill_done_q  <= 1'b0;
            fill_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        busy_q <= 1'b1;
                        if (bus.req_hit && (|bus.req_hit_way)) begin
                            way_access_q <= idx2oh(oh2idx(bus.req_hit_way));
                            state_q      <= ST_UPDATE;
                        end else begin
                            state_q <= ST_SELECT;
                        end
                    end
                end
                ST_SELECT: begin
                    victim_q  <= pick_way;
                    beat_q    <= '0;
                    tmo_q     <= '0;
                    mem_req_q <= 1'b1;
                    state_q   <= ST_FILL;
                end
                ST_FILL: begin
                    // An ack always wins over the timeout terminal count.
                    if (bus.mem_ack) begin
                        beat_q <= beat_q + 4'd1;
                        tmo_q  <= '0;
                        if (beat_q == 4'(LINE_BEATS - 1)) begin
                            mem_req_q    <= 1'b0;
                            way_access_q <= idx2oh(victim_q);
                            fill_done_q  <= 1'b1;
                            state_q      <= ST_UPDATE;
                        end
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                        if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                            fill_err_q <= 1'b1;
                            mem_req_q  <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= ST_IDLE;
                        end
                    end
                end
                ST_UPDATE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.fill_beat  = beat_q;
    assign bus.victim_way = victim_q;
    assign bus.way_access = way_access_q;
    assign bus.busy       = busy_q;
    assign bus.fill_done  = fill_done_q;
    assign bus.fill_err   = fill_err_q;

endmodule

// File: tb/tb_lru_replace_ctrl.sv
// Randomized self-checking bench for lru_replace_ctrl against a transaction-level model
// of victim choice, fill length and ack timeout.
module tb_lru_replace_ctrl;

    localparam int BEATS = 4;
    localparam int TMO   = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   rr_m;
    int   victim_m;

    lru_replace_ctrl_if bus ();

    lru_replace_ctrl #(.LINE_BEATS(BEATS), .ACK_TIMEOUT(TMO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_memreq"}, 32'(bus.mem_req), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_access"}, 32'(bus.way_access), 0);
        chk({tag, "_done"}, 32'(bus.fill_done), 0);
        chk({tag, "_err"}, 32'(bus.fill_err), 0);
    endtask

    // Model of the replacement choice: invalid first, then first zero status bit, then round-robin.
    task automatic model_victim(input logic [3:0] inv, input logic [3:0] lru);
        int found;
        found = -1;
        for (int i = 0; i < 4; i++) if (found < 0 && inv[i]) found = i;
        for (int i = 0; i < 4; i++) if (found < 0 && !lru[i]) found = i;
        if (found < 0) begin
            found = rr_m;
            rr_m  = (rr_m + 1) % 4;
        end
        victim_m = found;
    endtask

    // mode: 0 ack every cycle, 1 every other, 2 never, 3 only at the last idle cycle before
    // timeout, 4 random. rst_at >= 0 asserts reset once that many beats have been accepted.
    task automatic run_req(input logic hit, input logic [3:0] hw, input logic [3:0] inv,
                           input logic [3:0] lru, input int mode, input int rst_at,
                           input int exp_victim);
        logic [3:0] exp_oh;
        int acks, idle, fill_cyc, req_cyc, thr;
        bit ack, done;
        bus.way_invalid = inv;
        bus.lru_status  = lru;
        bus.req_valid   = 1'b1;
        bus.req_hit     = hit;
        bus.req_hit_way = hw;
        step();
        bus.req_valid   = 1'b0;
        bus.req_hit     = 1'b0;
        bus.req_hit_way = '0;
        if (hit && hw != 4'd0) begin
            exp_oh = hw & (~hw + 4'd1);
            chk("hit_access", 32'(bus.way_access), 32'(exp_oh));
            chk("hit_busy", 32'(bus.busy), 1);
            chk("hit_memreq", 32'(bus.mem_req), 0);
            chk("hit_done", 32'(bus.fill_done), 0);
            step();
            check_idle_outputs("hit_after");
            chk("hit_victim_held", 32'(bus.victim_way), 32'(victim_m));
            return;
        end
        chk("sel_busy", 32'(bus.busy), 1);
        chk("sel_memreq", 32'(bus.mem_req), 0);
        model_victim(inv, lru);
        if (exp_victim >= 0) chk("victim_directed", 32'(victim_m), 32'(exp_victim));
        step();
        chk("fill_memreq", 32'(bus.mem_req), 1);
        chk("victim", 32'(bus.victim_way), 32'(victim_m));
        acks = 0; idle = 0; fill_cyc = 0; req_cyc = 1; done = 0;
        thr = $urandom_range(2, 9);
        while (!done) begin
            chk("fill_beat", 32'(bus.fill_beat), 32'(acks));
            if (acks == rst_at) begin
                #2 reset = 1'b1;
                #1;
                chk("rst_memreq", 32'(bus.mem_req), 0);
                chk("rst_busy", 32'(bus.busy), 0);
                chk("rst_beat", 32'(bus.fill_beat), 0);
                chk("rst_victim", 32'(bus.victim_way), 0);
                rr_m = 0; victim_m = 0;
                step();
                reset = 1'b0;
                return;
            end
            fill_cyc++;
            case (mode)
                0: ack = 1'b1;
                1: ack = (fill_cyc % 2) == 0;
                2: ack = 1'b0;
                3: ack = (idle == TMO - 1);
                default: ack = $urandom_range(0, 9) < thr;
            endcase
            bus.mem_ack     = ack;
            bus.req_valid   = 1'($urandom);
            bus.req_hit     = 1'($urandom);
            bus.req_hit_way = 4'($urandom);
            step();
            bus.mem_ack = 1'b0;
            if (ack) begin acks++; idle = 0; end
            else idle++;
            if (acks == BEATS) begin
                chk("end_memreq", 32'(bus.mem_req), 0);
                chk("end_done", 32'(bus.fill_done), 1);
                chk("end_access", 32'(bus.way_access), 32'(1 << victim_m));
                chk("end_busy", 32'(bus.busy), 1);
                bus.req_valid = 1'b0;
                step();
                check_idle_outputs("upd_after");
                done = 1;
            end else if (idle == TMO) begin
                chk("tmo_err", 32'(bus.fill_err), 1);
                chk("tmo_memreq", 32'(bus.mem_req), 0);
                chk("tmo_busy", 32'(bus.busy), 0);
                chk("tmo_access", 32'(bus.way_access), 0);
                chk("tmo_victim_held", 32'(bus.victim_way), 32'(victim_m));
                chk("tmo_cycles", 32'(req_cyc), 32'(fill_cyc));
                bus.req_valid = 1'b0;
                step();
                check_idle_outputs("tmo_after");
                done = 1;
            end else begin
                chk("fill_memreq_hold", 32'(bus.mem_req), 1);
                chk("fill_busy", 32'(bus.busy), 1);
                chk("fill_access", 32'(bus.way_access), 0);
                chk("fill_done_low", 32'(bus.fill_done), 0);
                req_cyc++;
                if (fill_cyc > 200) begin
                    chk("fill_budget", 32'(fill_cyc), 200);
                    done = 1;
                end
            end
        end
        if (mode == 1) chk("memreq_cycles", 32'(req_cyc), 2 * BEATS);
        bus.req_valid   = 1'b0;
        bus.req_hit     = 1'b0;
        bus.req_hit_way = '0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; rr_m = 0; victim_m = 0;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_hit = 1'b0; bus.req_hit_way = '0;
        bus.way_invalid = '0; bus.lru_status = '0; bus.mem_ack = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        chk("reset_beat", 32'(bus.fill_beat), 0);
        chk("reset_victim", 32'(bus.victim_way), 0);
        reset = 1'b0;
        bus.mem_ack = 1'b1;
        step();
        check_idle_outputs("idle_ack_ignored");
        bus.mem_ack = 1'b0;

        run_req(1'b1, 4'b0100, 4'b0000, 4'b0000, 0, -1, -1);
        run_req(1'b1, 4'b1010, 4'b0000, 4'b0000, 0, -1, -1);
        run_req(1'b0, 4'b0000, 4'b1010, 4'b1110, 0, -1, 1);
        run_req(1'b0, 4'b0000, 4'b0000, 4'b1011, 1, -1, 2);
        run_req(1'b0, 4'b0000, 4'b0000, 4'b1111, 0, -1, 0);
        run_req(1'b0, 4'b0000, 4'b0000, 4'b1111, 0, -1, 1);
        run_req(1'b0, 4'b0000, 4'b0000, 4'b1111, 0, -1, 2);
        run_req(1'b1, 4'b0000, 4'b0000, 4'b0111, 2, -1, 3);
        run_req(1'b0, 4'b0000, 4'b0100, 4'b0000, 3, -1, 2);
        run_req(1'b0, 4'b0000, 4'b0000, 4'b1111, 0, 2, 3);
        run_req(1'b0, 4'b0000, 4'b0000, 4'b1111, 0, -1, 0);

        for (int t = 0; t < 40; t++) begin
            logic [3:0] inv_r, lru_r;
            inv_r = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'd0;
            lru_r = ($urandom_range(0, 2) == 0) ? 4'hf : 4'($urandom);
            run_req(1'($urandom_range(0, 2) == 0), 4'($urandom), inv_r, lru_r, 4, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
